typed_regfile: RTL

Parametrised software-visible register file: one byte-enabled write port and NUM_RD_PORTS registered read ports. Each register has its own access type and reset value. Hardware-side update and event-set inputs sit beside the bus side. The block sits between the bus-slave adapter and peripheral logic, and is the general replacement for the fixed-map 32-bit register files.

---
 rtl/typed_regfile_pkg.sv | 50 +++++
 rtl/typed_regfile_rd_port.sv | 77 +++++++
 rtl/typed_regfile.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/typed_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : typed_regfile_pkg
// Description : Access-type encodings and decode helpers shared by the typed
//               register file and its read ports.
// Revision    : 1.0 - initial release
// ============================================================================
package typed_regfile_pkg;

    // Per-register access types; encodings 7 and above behave as RO
    localparam logic [2:0] RW  = 3'd0;
    localparam logic [2:0] RO  = 3'd1;
    localparam logic [2:0] RC  = 3'd2;
    localparam logic [2:0] WO  = 3'd3;
    localparam logic [2:0] W1C = 3'd4;
    localparam logic [2:0] W1S = 3'd5;
    localparam logic [2:0] W1  = 3'd6;

    // Widest register the helpers handle; callers size-cast the result down
    localparam int c_MAX_DATA_WIDTH = 256;
    localparam int c_MAX_BYTES      = c_MAX_DATA_WIDTH / 8;

    // Expand byte enables into a per-bit mask
    function automatic logic [c_MAX_DATA_WIDTH-1:0] be_to_mask(
        input logic [c_MAX_BYTES-1:0] be
    );
        logic [c_MAX_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int b = 0; b < c_MAX_BYTES; b++) begin
            mask[b*8 +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

    // Byte address is legal when word aligned and inside the register array
    function automatic logic is_legal(
        input logic [31:0] addr,
        input int          num_regs,
        input int          data_width
    );
        logic [31:0] nbytes;
        nbytes = 32'(data_width / 8);
        if ((addr & (nbytes - 32'd1)) != 32'd0) begin
            return 1'b0;
        end
        return (addr / nbytes) < 32'(num_regs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/typed_regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : typed_regfile_rd_port
// Description : One registered read port: address decode, type-aware data
//               select, and read-clear hit reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module typed_regfile_rd_port
    import typed_regfile_pkg::*;
#(
    parameter int                      DATA_WIDTH = 32,
    parameter int                      ADDR_WIDTH = 8,
    parameter int                      NUM_REGS   = 8,
    parameter logic [NUM_REGS*3-1:0]   REG_TYPES  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rd_en,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_valid,
    output logic                           rd_err,
    output logic [NUM_REGS-1:0]            rc_hit
);

    localparam int c_ALIGN = $clog2(DATA_WIDTH / 8);

    logic                  w_legal;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [NUM_REGS-1:0]   w_rc_hit;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rd_err;

    assign w_legal = is_legal(32'(rd_addr), NUM_REGS, DATA_WIDTH);
    assign w_word  = rd_addr >> c_ALIGN;

    // Select the addressed register (WO reads as zero) and flag RC hits
    always_comb begin
        w_rdata  = '0;
        w_rc_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_legal && (w_word == ADDR_WIDTH'(i))) begin
                if (REG_TYPES[i*3 +: 3] != WO) begin
                    w_rdata = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
                end
                if (rd_en && (REG_TYPES[i*3 +: 3] == RC)) begin
                    w_rc_hit[i] = 1'b1;
                end
            end
        end
    end

    // Capture read response; data holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_err   <= rd_en && !w_legal;
            if (rd_en) begin
                r_rd_data <= w_rdata;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_err   = r_rd_err;
    assign rc_hit   = w_rc_hit;

endmodule
`default_nettype wire

// File: rtl/typed_regfile.sv
`default_nettype none
// ============================================================================
// Module      : typed_regfile
// Description : Parametrised register file with per-register access types,
//               one byte-enabled write port, NUM_RD_PORTS registered read
//               ports, and hardware load / bit-set inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module typed_regfile
    import typed_regfile_pkg::*;
#(
    parameter int                                DATA_WIDTH   = 32,
    parameter int                                ADDR_WIDTH   = 8,
    parameter int                                NUM_REGS     = 8,
    parameter int                                NUM_RD_PORTS = 2,
    parameter logic [NUM_REGS*3-1:0]             REG_TYPES    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]    RESET_VALUES = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [DATA_WIDTH/8-1:0]            wr_be,
    output logic                               wr_err,
    input  logic [NUM_RD_PORTS-1:0]            rd_en,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_valid,
    output logic [NUM_RD_PORTS-1:0]            rd_err,
    input  logic [NUM_REGS-1:0]                hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]     hw_wdata,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]     hw_set,
    output logic [NUM_REGS*DATA_WIDTH-1:0]     reg_q,
    output logic [NUM_REGS-1:0]                lock_q
);

    localparam int c_ALIGN = $clog2(DATA_WIDTH / 8);

    logic                  w_wr_legal;
    logic [ADDR_WIDTH-1:0] w_wr_word;
    logic [DATA_WIDTH-1:0] w_wr_mask;
    logic [NUM_REGS-1:0]   w_lock_err;
    logic [NUM_REGS-1:0]   w_rc_clr;
    logic [NUM_REGS-1:0]   w_rc_hit [NUM_RD_PORTS];
    logic                  r_wr_err;
    logic                  w_unused;

    assign w_wr_legal = is_legal(32'(wr_addr), NUM_REGS, DATA_WIDTH);
    assign w_wr_word  = wr_addr >> c_ALIGN;
    assign w_wr_mask  = DATA_WIDTH'(be_to_mask(c_MAX_BYTES'(wr_be)));

    // Hardware data lanes of registers whose type ignores them are dropped
    assign w_unused = ^{hw_wdata, hw_set};

    // Read ports
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        typed_regfile_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_REGS   (NUM_REGS),
            .REG_TYPES  (REG_TYPES)
        ) u_rd_port (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en[p]),
            .rd_addr  (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .reg_q    (reg_q),
            .rd_data  (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid (rd_valid[p]),
            .rd_err   (rd_err[p]),
            .rc_hit   (w_rc_hit[p])
        );
    end

    // Several ports hitting the same RC register clear it only once
    always_comb begin
        w_rc_clr = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            w_rc_clr = w_rc_clr | w_rc_hit[p];
        end
    end

    // Register storage; per-bit priority is hw_set > hw_we > write > read-clear
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [2:0]            c_TYPE    = REG_TYPES[i*3 +: 3];
        localparam logic [DATA_WIDTH-1:0] c_RESET   = RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
        localparam logic                  c_HW_LOAD = (c_TYPE == RW) || (c_TYPE == RO) || (c_TYPE > W1);
        localparam logic                  c_HW_SET  = (c_TYPE == RC) || (c_TYPE == W1C) || (c_TYPE == W1S);

        logic                  w_sel;
        logic [DATA_WIDTH-1:0] w_d;
        logic [DATA_WIDTH-1:0] w_next;
        logic                  w_lock_set;
        logic                  w_err;
        logic [DATA_WIDTH-1:0] r_q;
        logic                  r_lock;

        assign w_sel = wr_en && w_wr_legal && (w_wr_word == ADDR_WIDTH'(i));
        assign w_d   = wr_data & w_wr_mask;

        // Next register value from all update sources
        always_comb begin
            w_next     = w_rc_clr[i] ? '0 : r_q;
            w_lock_set = 1'b0;
            w_err      = 1'b0;
            if (w_sel) begin
                case (c_TYPE)
                    RW, WO: w_next = (w_next & ~w_wr_mask) | w_d;
                    W1C:    w_next = w_next & ~w_d;
                    W1S:    w_next = w_next | w_d;
                    W1: begin
                        if (r_lock) begin
                            w_err = 1'b1;
                        end else begin
                            w_next     = (w_next & ~w_wr_mask) | w_d;
                            w_lock_set = |wr_be;
                        end
                    end
                    default: ;
                endcase
            end
            if (c_HW_LOAD && hw_we[i]) begin
                w_next = hw_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (c_HW_SET) begin
                w_next = w_next | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Register contents and sticky write-once lock
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q    <= c_RESET;
                r_lock <= 1'b0;
            end else begin
                r_q <= w_next;
                if (w_lock_set) begin
                    r_lock <= 1'b1;
                end
            end
        end

        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_q;
        assign lock_q[i]                         = r_lock;
        assign w_lock_err[i]                     = w_err;
    end

    // Write error: illegal address or a write to a locked write-once register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && (!w_wr_legal || (|w_lock_err));
        end
    end

    assign wr_err = r_wr_err;

endmodule
`default_nettype wire
